// File: rtl/alu_sequencer.sv
// Operand/control stage for a 16-bit combinational ALU with an 8-entry register file.
// Optional macro ALU_SEQ_FLAGS_EN registers a zero flag alongside each writeback.
module alu_sequencer #(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_valid,
  input  logic [2:0]    ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [15:0]   instr,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_s,
  input  logic [DW-1:0] alu_q,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          zero
);

  // state | meaning
  // IDLE  | accept a register load or an instruction
  // OPS   | drive operands and opcode to the ALU
  // EXEC  | capture the ALU result
  // WB    | write back to rd, raise done on the following cycle
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OPS  = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [2:0]    rd_q, rd_d;
  logic [2:0]    ra_q, ra_d;
  logic [2:0]    rb_q, rb_d;
  logic [DW-1:0] alu_a_q, alu_a_d;
  logic [DW-1:0] alu_b_q, alu_b_d;
  logic [2:0]    alu_s_q, alu_s_d;
  logic [DW-1:0] cap_q, cap_d;
  logic [DW-1:0] result_q, result_d;
  logic          done_q, done_d;
  logic [DW-1:0] rf_q [NREG];
  logic [DW-1:0] rf_d [NREG];

  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[3:0];

  // Gated by rst_n so the producer never sees a handshake while reset is held.
  assign instr_ready = rst_n & (state_q == S_IDLE) & ~ld_valid;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_s_d  = alu_s_q;
    cap_d    = cap_q;
    result_d = result_q;
    done_d   = 1'b0;
    rf_d     = rf_q;
    case (state_q)
      S_IDLE: begin
        if (ld_valid) begin
          rf_d[ld_addr] = ld_data;
        end else if (instr_valid) begin
          op_d    = instr[15:13];
          rd_d    = instr[12:10];
          ra_d    = instr[9:7];
          rb_d    = instr[6:4];
          state_d = S_OPS;
        end
      end
      S_OPS: begin
        alu_a_d = rf_q[ra_q];
        alu_b_d = rf_q[rb_q];
        alu_s_d = op_q;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        cap_d   = alu_q;
        state_d = S_WB;
      end
      S_WB: begin
        rf_d[rd_q] = cap_q;
        result_d   = cap_q;
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_s_q  <= '0;
      cap_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_s_q  <= alu_s_d;
      cap_q    <= cap_d;
      result_q <= result_d;
      done_q   <= done_d;
      rf_q     <= rf_d;
    end
  end

  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  assign alu_s  = alu_s_q;
  assign done   = done_q;
  assign result = result_q;

`ifdef ALU_SEQ_FLAGS_EN
  logic zero_q, zero_d;

  always_comb begin
    zero_d = zero_q;
    if (state_q == S_WB) zero_d = (cap_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) zero_q <= 1'b0;
    else        zero_q <= zero_d;
  end

  assign zero = zero_q;
`else
  assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural model of the downstream ALU.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] alu_a, alu_b, alu_q;
  logic [2:0]  alu_s;
  logic        done;
  logic [15:0] result;
  logic        zero;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_q(alu_q),
    .done(done), .result(result), .zero(zero)
  );

  // ALU: 0 clear, 1 add, 2 |a-b|, 3 pass a, 4 xor, 5 or, 6 and, 7 a+1
  always_comb begin
    case (alu_s)
      3'd0: alu_q = 16'h0000;
      3'd1: alu_q = alu_a + alu_b;
      3'd2: alu_q = (alu_a >= alu_b) ? alu_a - alu_b : alu_b - alu_a;
      3'd3: alu_q = alu_a;
      3'd4: alu_q = alu_a ^ alu_b;
      3'd5: alu_q = alu_a | alu_b;
      3'd6: alu_q = alu_a & alu_b;
      default: alu_q = alu_a + 16'd1;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge in IDLE; returns at a negedge in IDLE.
  task automatic load(input logic [2:0] a, input logic [15:0] d);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  // Caller is at a negedge in IDLE. Optionally attempts a load while in EXEC.
  task automatic run(input string tag, input logic [2:0] op, input logic [2:0] rd,
                     input logic [2:0] ra, input logic [2:0] rb,
                     input logic [15:0] exp_a, input logic [15:0] exp_b,
                     input logic [15:0] exp_r, input bit ld_in_exec);
    int lat;
    instr_valid = 1'b1;
    instr = {op, rd, ra, rb, 4'h5};
    #1;
    chk({tag, ".ready"}, instr_ready, 1);
    @(posedge clk);
    lat = 9;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin
        instr_valid = 1'b0;
        instr = 16'hFFFF;
      end
      if (i == 2) begin
        chk({tag, ".alu_a"}, alu_a, exp_a);
        chk({tag, ".alu_b"}, alu_b, exp_b);
        chk({tag, ".alu_s"}, alu_s, op);
        if (ld_in_exec) begin
          ld_valid = 1'b1; ld_addr = ra; ld_data = 16'hBEEF;
        end
      end
      if (i == 3) ld_valid = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
    end
    chk({tag, ".latency"}, lat, 4);
    chk({tag, ".result"}, result, exp_r);
    @(negedge clk);
    chk({tag, ".done_pulse"}, done, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    instr_valid = 1'b0; instr = '0;

    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ld_valid = 1'($urandom); ld_addr = 3'($urandom); ld_data = 16'($urandom);
      instr_valid = 1'($urandom); instr = 16'($urandom);
      #1;
      chk("rst.ready", instr_ready, 0);
      chk("rst.outs", {alu_a, alu_b}, 0);
      chk("rst.ctl", {alu_s, done, zero, result}, 0);
    end
    @(negedge clk);
    ld_valid = 1'b0; instr_valid = 1'b0; instr = '0;
    rst_n = 1'b1;
    @(negedge clk);
    run("rst_read", 3'd3, 3'd1, 3'd5, 3'd5, 16'd0, 16'd0, 16'd0, 1'b0);

    // Load and add
    load(3'd1, 16'd10);
    load(3'd2, 16'd11);
    run("add", 3'd1, 3'd3, 3'd1, 3'd2, 16'd10, 16'd11, 16'd21, 1'b0);
    run("rd_wb", 3'd3, 3'd4, 3'd3, 3'd3, 16'd21, 16'd21, 16'd21, 1'b0);

    // Abs diff and logic ops
    run("absd12", 3'd2, 3'd6, 3'd1, 3'd2, 16'd10, 16'd11, 16'd1, 1'b0);
    run("absd21", 3'd2, 3'd6, 3'd2, 3'd1, 16'd11, 16'd10, 16'd1, 1'b0);
    run("xor", 3'd4, 3'd6, 3'd1, 3'd2, 16'd10, 16'd11, 16'h0001, 1'b0);
    run("or",  3'd5, 3'd6, 3'd1, 3'd2, 16'd10, 16'd11, 16'h000B, 1'b0);
    run("and", 3'd6, 3'd6, 3'd1, 3'd2, 16'd10, 16'd11, 16'h000A, 1'b0);
    chk("zero_nz", zero, 0);
    run("inc", 3'd7, 3'd6, 3'd1, 3'd1, 16'd10, 16'd10, 16'd11, 1'b0);
    run("clr", 3'd0, 3'd7, 3'd1, 3'd2, 16'd10, 16'd11, 16'd0, 1'b0);
`ifdef ALU_SEQ_FLAGS_EN
    chk("zero_set", zero, 1);
`else
    chk("zero_tied", zero, 0);
`endif

    // Load wins over a simultaneous instruction
    ld_valid = 1'b1; ld_addr = 3'd6; ld_data = 16'h1234;
    instr_valid = 1'b1; instr = {3'd3, 3'd7, 3'd6, 3'd6, 4'h0};
    #1;
    chk("prio.ready", instr_ready, 0);
    @(negedge clk);
    ld_valid = 1'b0;
    run("prio", 3'd3, 3'd7, 3'd6, 3'd6, 16'h1234, 16'h1234, 16'h1234, 1'b0);

    // Load during EXEC is dropped
    run("busy_ld", 3'd3, 3'd0, 3'd1, 3'd1, 16'd10, 16'd10, 16'd10, 1'b1);
    run("busy_chk", 3'd3, 3'd0, 3'd1, 3'd1, 16'd10, 16'd10, 16'd10, 1'b0);

    // Overwrite with wrap
    load(3'd5, 16'hFFFF);
    run("wrap", 3'd7, 3'd5, 3'd5, 3'd5, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0);
    run("wrap_rd", 3'd3, 3'd0, 3'd5, 3'd5, 16'h0000, 16'h0000, 16'h0000, 1'b0);

    // Reset during EXEC
    instr_valid = 1'b1; instr = {3'd1, 3'd3, 3'd1, 3'd2, 4'h0};
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("mid.alu_a_pre", alu_a, 16'd10);
    rst_n = 1'b0;
    #1;
    chk("mid.ops", {alu_a, alu_b, 13'(alu_s)}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid.no_done", {done, result}, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid.done_after", done, 0);
    run("mid_r1", 3'd1, 3'd0, 3'd1, 3'd2, 16'd0, 16'd0, 16'd0, 1'b0);
    run("mid_r3", 3'd3, 3'd0, 3'd3, 3'd3, 16'd0, 16'd0, 16'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
